// File: rtl/motor_driver.sv
// motor_driver: receiver for the 2-bit motor command bus, driving an H-bridge
// (in1/in2 direction pins plus a PWM enable). Coasts for DEAD_TIME cycles on any
// reversal or brake-to-drive change.
// Build option MOTOR_RAMP_EN: when defined, duty soft-starts from zero on drive
// entry and climbs by RAMP_STEP once per PWM period. When undefined, duty jumps
// straight to the target and no ramp logic is built.
//
// state | meaning
// IDLE  | coast, bridge off
// FWD   | forward drive, ena carries PWM
// BACK  | backward drive, ena carries PWM
// BRAKE | both low-side on, ena solid high
// DEAD  | forced coast for DEAD_TIME cycles before a new drive direction
module motor_driver #(
   parameter int unsigned PWM_PERIOD = 1000,
   parameter int unsigned FWD_DUTY   = 700,
   parameter int unsigned BACK_DUTY  = 500,
   parameter int unsigned RAMP_STEP  = 50,
   parameter int unsigned DEAD_TIME  = 200000
) (
   input  logic       clkus,
   input  logic       rst,
   input  logic [1:0] motor,
   output logic       in1,
   output logic       in2,
   output logic       ena,
   output logic       moving,
   output logic       dead
);
   localparam int unsigned   DW        = $clog2(DEAD_TIME + 1);
   localparam logic [15:0]   PWM_LAST  = 16'(PWM_PERIOD - 1);
   localparam logic [15:0]   FWD_TGT   = 16'(FWD_DUTY);
   localparam logic [15:0]   BACK_TGT  = 16'(BACK_DUTY);
   localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_TIME);

   typedef enum logic [4:0] {
      IDLE  = 5'b00001,
      FWD   = 5'b00010,
      BACK  = 5'b00100,
      BRAKE = 5'b01000,
      DEAD  = 5'b10000
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   pwm_cnt_q, pwm_cnt_d;
   logic [15:0]   duty_q, duty_d;
   logic [15:0]   target;
   logic [DW-1:0] dead_cnt_q, dead_cnt_d;
   logic          in1_q, in2_q, ena_q, moving_q, dead_q;
   logic          in1_d, in2_d, ena_d, moving_d, dead_d;
   logic          period_end, drive_d, entering;
`ifdef MOTOR_RAMP_EN
   logic [16:0]   duty_sum;
`endif

   // Direct command decode, used from IDLE and when dead time expires.
   function automatic state_t cmd_state(input logic [1:0] cmd);
      case (cmd)
         2'b01:   return FWD;
         2'b10:   return BACK;
         2'b11:   return BRAKE;
         default: return IDLE;
      endcase
   endfunction

   // Next-state decode; any reversal or brake-to-drive detours through DEAD.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  state_d = cmd_state(motor);
         FWD: begin
            case (motor)
               2'b00:   state_d = IDLE;
               2'b10:   state_d = DEAD;
               2'b11:   state_d = BRAKE;
               default: state_d = FWD;
            endcase
         end
         BACK: begin
            case (motor)
               2'b00:   state_d = IDLE;
               2'b01:   state_d = DEAD;
               2'b11:   state_d = BRAKE;
               default: state_d = BACK;
            endcase
         end
         BRAKE: begin
            case (motor)
               2'b00:   state_d = IDLE;
               2'b11:   state_d = BRAKE;
               default: state_d = DEAD;
            endcase
         end
         DEAD: begin
            if (dead_cnt_q == DW'(1)) state_d = cmd_state(motor);
         end
         default: state_d = IDLE;
      endcase
   end

   // PWM counter, dead-time down-counter, duty update and output decode from next state.
   always_comb begin
      period_end = (pwm_cnt_q == PWM_LAST);
      pwm_cnt_d  = period_end ? 16'd0 : pwm_cnt_q + 16'd1;
      drive_d    = (state_d == FWD) || (state_d == BACK);
      entering   = drive_d && (state_d != state_q);
      target     = (state_d == FWD) ? FWD_TGT : BACK_TGT;

      dead_cnt_d = '0;
      if (state_d == DEAD) begin
         dead_cnt_d = (state_q == DEAD) ? dead_cnt_q - DW'(1) : DEAD_LOAD;
      end

      duty_d = '0;
`ifdef MOTOR_RAMP_EN
      duty_sum = {1'b0, duty_q} + 17'(RAMP_STEP);
      if (entering) begin
         duty_d = '0;
      end else if (drive_d) begin
         if (period_end) begin
            duty_d = (duty_sum > {1'b0, target}) ? target : duty_sum[15:0];
         end else begin
            duty_d = duty_q;
         end
      end
`else
      if (entering) begin
         duty_d = target;
      end else if (drive_d) begin
         duty_d = duty_q;
      end
`endif

      in1_d    = (state_d == FWD)  || (state_d == BRAKE);
      in2_d    = (state_d == BACK) || (state_d == BRAKE);
      ena_d    = (state_d == BRAKE) || (drive_d && (pwm_cnt_d < duty_d));
      moving_d = drive_d;
      dead_d   = (state_d == DEAD);
   end

   // State, counters and registered bridge outputs with synchronous reset.
   always_ff @(posedge clkus) begin
      if (rst) begin
         state_q    <= IDLE;
         pwm_cnt_q  <= '0;
         duty_q     <= '0;
         dead_cnt_q <= '0;
         in1_q      <= 1'b0;
         in2_q      <= 1'b0;
         ena_q      <= 1'b0;
         moving_q   <= 1'b0;
         dead_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pwm_cnt_q  <= pwm_cnt_d;
         duty_q     <= duty_d;
         dead_cnt_q <= dead_cnt_d;
         in1_q      <= in1_d;
         in2_q      <= in2_d;
         ena_q      <= ena_d;
         moving_q   <= moving_d;
         dead_q     <= dead_d;
      end
   end

   assign in1    = in1_q;
   assign in2    = in2_q;
   assign ena    = ena_q;
   assign moving = moving_q;
   assign dead   = dead_q;

endmodule
